// File: rtl/encoder_8_3_rr.sv
// Round-robin 8-to-3 encoder: captures one request from an 8-bit vector,
// presents it as a binary code plus one-hot grant, and holds it until ack.
module encoder_8_3_rr #(
    parameter int N_REQ = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] y,
    output logic [7:0] grant,
    output logic       valid,
    output logic       multi
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] ptr;
    logic [2:0] ptr_next;
    logic [2:0] y_next;
    logic [7:0] grant_next;
    logic       valid_next;
    logic       multi_next;
    logic [2:0] sel;
    logic       found;
    logic [2:0] idx;

    // Scan starts just after the last granted index and wraps, so that
    // index is visited last and each held requester gets its turn.
    always_comb begin
        sel   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        y_next     = y;
        grant_next = grant;
        valid_next = valid;
        multi_next = multi;
        case (state)
            IDLE: begin
                if (en && (req != 8'h00)) begin
                    y_next     = sel;
                    grant_next = 8'b1 << sel;
                    valid_next = 1'b1;
                    multi_next = ((req & (req - 8'd1)) != 8'h00);
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // y and multi keep their last values once the grant is accepted.
                if (ack) begin
                    valid_next = 1'b0;
                    grant_next = 8'h00;
                    ptr_next   = y;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 3'd7;
            y     <= 3'd0;
            grant <= 8'h00;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            y     <= y_next;
            grant <= grant_next;
            valid <= valid_next;
            multi <= multi_next;
        end
    end

endmodule

// File: tb/tb_encoder_8_3_rr.sv
// Directed bench for encoder_8_3_rr: reset, capture, hold, round-robin
// order, disabled operation, reset during grant and back-to-back acks.
module tb_encoder_8_3_rr;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] y;
    logic [7:0] grant;
    logic       valid;
    logic       multi;

    int checks = 0;
    int errors = 0;

    encoder_8_3_rr dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req   (req),
        .ack   (ack),
        .y     (y),
        .grant (grant),
        .valid (valid),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        req   = 8'h00;
        ack   = 1'b0;
        step();
        step();
        checks++;
        if (valid !== 1'b0 || y !== 3'd0 || grant !== 8'h00 || multi !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: valid=%b y=%0d grant=%h multi=%b, required 0 0 00 0",
                     valid, y, grant, multi);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_capture();
        en  = 1'b1;
        req = 8'b0000_0100;
        step();
        checks++;
        if (valid !== 1'b1 || y !== 3'd2 || grant !== 8'h04 || multi !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_capture: valid=%b y=%0d grant=%h multi=%b, required 1 2 04 0",
                     valid, y, grant, multi);
        end
    endtask

    task automatic test_hold();
        req = 8'h00;
        en  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (valid !== 1'b1 || y !== 3'd2 || grant !== 8'h04) begin
                errors++;
                $display("[TB] FAIL hold[%0d]: valid=%b y=%0d grant=%h, required 1 2 04",
                         i, valid, y, grant);
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || grant !== 8'h00 || y !== 3'd2) begin
            errors++;
            $display("[TB] FAIL hold_ack: valid=%b grant=%h y=%0d, required 0 00 2",
                     valid, grant, y);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_y [4];
        exp_y[0] = 3'd7;
        exp_y[1] = 3'd0;
        exp_y[2] = 3'd2;
        exp_y[3] = 3'd7;
        req = 8'b1000_0101;
        en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (valid !== 1'b1 || y !== exp_y[i] || grant !== (8'b1 << exp_y[i]) || multi !== 1'b1) begin
                errors++;
                $display("[TB] FAIL round_robin[%0d]: valid=%b y=%0d grant=%h multi=%b, required 1 %0d %h 1",
                         i, valid, y, grant, multi, exp_y[i], 8'b1 << exp_y[i]);
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
            checks++;
            if (valid !== 1'b0 || grant !== 8'h00) begin
                errors++;
                $display("[TB] FAIL round_robin_ack[%0d]: valid=%b grant=%h, required 0 00",
                         i, valid, grant);
            end
            if (i == 3) begin
                en  = 1'b0;
                req = 8'h00;
            end
        end
    endtask

    task automatic test_disabled();
        en  = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (valid !== 1'b0 || grant !== 8'h00) begin
                errors++;
                $display("[TB] FAIL disabled[%0d]: valid=%b grant=%h, required 0 00",
                         i, valid, grant);
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || grant !== 8'h00 || y !== 3'd7) begin
            errors++;
            $display("[TB] FAIL idle_ack: valid=%b grant=%h y=%0d, required 0 00 7",
                     valid, grant, y);
        end
        // Pointer still at 7 after the ignored ack, so the scan starts at 0.
        en = 1'b1;
        step();
        checks++;
        if (valid !== 1'b1 || y !== 3'd0 || grant !== 8'h01 || multi !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_idle_capture: valid=%b y=%0d grant=%h multi=%b, required 1 0 01 1",
                     valid, y, grant, multi);
        end
        ack = 1'b1;
        en  = 1'b0;
        step();
        ack = 1'b0;
    endtask

    task automatic test_reset_in_grant();
        en  = 1'b1;
        req = 8'h20;
        step();
        checks++;
        if (valid !== 1'b1 || y !== 3'd5 || grant !== 8'h20 || multi !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_reset_grant: valid=%b y=%0d grant=%h multi=%b, required 1 5 20 0",
                     valid, y, grant, multi);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (valid !== 1'b0 || y !== 3'd0 || grant !== 8'h00 || multi !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_grant: valid=%b y=%0d grant=%h multi=%b, required 0 0 00 0",
                     valid, y, grant, multi);
        end
        req = 8'hFF;
        step();
        checks++;
        if (valid !== 1'b1 || y !== 3'd0 || grant !== 8'h01 || multi !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ptr_restored: valid=%b y=%0d grant=%h multi=%b, required 1 0 01 1",
                     valid, y, grant, multi);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_y [2];
        exp_y[0] = 3'd3;
        exp_y[1] = 3'd4;
        req = 8'b0001_1000;
        en  = 1'b1;
        ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (valid !== 1'b0 || grant !== 8'h00) begin
                errors++;
                $display("[TB] FAIL b2b_gap[%0d]: valid=%b grant=%h, required 0 00",
                         i, valid, grant);
            end
            step();
            checks++;
            if (valid !== 1'b1 || y !== exp_y[i] || grant !== (8'b1 << exp_y[i]) || multi !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_grant[%0d]: valid=%b y=%0d grant=%h multi=%b, required 1 %0d %h 1",
                         i, valid, y, grant, multi, exp_y[i], 8'b1 << exp_y[i]);
            end
        end
        ack = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        req   = 8'h00;
        ack   = 1'b0;
        test_reset();
        test_single_capture();
        test_hold();
        test_round_robin();
        test_disabled();
        test_reset_in_grant();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
